popcount_frame_acc: RTL

- Streaming stage that sits directly downstream of the per-word bit counter.
- Accepts a framed stream of DATA_WIDTH-bit words over a valid/ready handshake and counts the 1 bits in each word.
- Accumulates a running total per frame and presents the frame total, word count and truncation flag on a held output handshake.
- Feeds frame-level statistics to later consumers.

---
 rtl/popcount_pkg.sv | 23 ++
 rtl/popcount_frame_acc_if.sv | 38 +++
 rtl/popcount_word.sv | 19 +
 rtl/popcount_frame_acc.sv | 114 +++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// Shared types and width helpers for the frame popcount accumulator.
package popcount_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DONE  = 2'd1,
        ST_DROP  = 2'd2
    } state_e;

    function automatic int unsigned cnt_w(input int unsigned data_width,
                                          input int unsigned max_words);
        return $clog2(data_width * max_words + 1);
    endfunction

    function automatic int unsigned wrd_w(input int unsigned max_words);
        return $clog2(max_words + 1);
    endfunction

    function automatic int unsigned pc_w(input int unsigned data_width);
        return $clog2(data_width) + 1;
    endfunction

endpackage

// File: rtl/popcount_frame_acc_if.sv
// Input beat stream and held frame-result handshake of popcount_frame_acc.
// dout_max exists only when POPCOUNT_FRAME_MAX_EN is defined.
interface popcount_frame_acc_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_WORDS  = 64
);
    import popcount_pkg::*;

    localparam int unsigned CNT_W = cnt_w(DATA_WIDTH, MAX_WORDS);
    localparam int unsigned WRD_W = wrd_w(MAX_WORDS);
    localparam int unsigned PC_W  = pc_w(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] din;
    logic                  din_valid;
    logic                  din_last;
    logic                  din_ready;
    logic [CNT_W-1:0]      dout;
    logic [WRD_W-1:0]      dout_words;
    logic                  dout_trunc;
    logic                  dout_valid;
    logic                  dout_ready;
`ifdef POPCOUNT_FRAME_MAX_EN
    logic [PC_W-1:0]       dout_max;
`endif

`ifdef POPCOUNT_FRAME_MAX_EN
    modport mst (output din, din_valid, din_last, dout_ready,
                 input  din_ready, dout, dout_words, dout_trunc, dout_valid, dout_max);
    modport slv (input  din, din_valid, din_last, dout_ready,
                 output din_ready, dout, dout_words, dout_trunc, dout_valid, dout_max);
`else
    modport mst (output din, din_valid, din_last, dout_ready,
                 input  din_ready, dout, dout_words, dout_trunc, dout_valid);
    modport slv (input  din, din_valid, din_last, dout_ready,
                 output din_ready, dout, dout_words, dout_trunc, dout_valid);
`endif

endinterface

// File: rtl/popcount_word.sv
// Combinational count of the 1 bits in one DATA_WIDTH-bit word.
module popcount_word #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0]                word_i,
    output logic [popcount_pkg::pc_w(DATA_WIDTH)-1:0] pop_c_o
);
    import popcount_pkg::*;

    localparam int unsigned PC_W = pc_w(DATA_WIDTH);

    always_comb begin
        pop_c_o = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            pop_c_o = pop_c_o + PC_W'(word_i[i]);
        end
    end

endmodule

// File: rtl/popcount_frame_acc.sv
// Per-frame popcount accumulator with a held result handshake; frames longer
// than MAX_WORDS are closed early and their tail dropped. Option: POPCOUNT_FRAME_MAX_EN.
module popcount_frame_acc #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_WORDS  = 64
) (
    input  logic             clk,
    input  logic             reset,
    popcount_frame_acc_if.slv bus
);
    import popcount_pkg::*;

    localparam int unsigned CNT_W = cnt_w(DATA_WIDTH, MAX_WORDS);
    localparam int unsigned WRD_W = wrd_w(MAX_WORDS);
    localparam int unsigned PC_W  = pc_w(DATA_WIDTH);

    state_e           state_q;
    logic [CNT_W-1:0] acc_q, acc_d, dout_q;
    logic [WRD_W-1:0] wcnt_q, wcnt_d, words_q;
    logic             trunc_q, rdy_q, vld_q;
    logic [PC_W-1:0]  pop;
    logic             accept, close;

    popcount_word #(.DATA_WIDTH(DATA_WIDTH)) u_word (
        .word_i  (bus.din),
        .pop_c_o (pop)
    );

    // Next-count values for the beat currently on the bus.
    always_comb begin
        acc_d  = acc_q + CNT_W'(pop);
        wcnt_d = wcnt_q + WRD_W'(1);
        accept = bus.din_valid && rdy_q;
        close  = bus.din_last || (wcnt_d == WRD_W'(MAX_WORDS));
    end

`ifdef POPCOUNT_FRAME_MAX_EN
    logic [PC_W-1:0] runmax_q, runmax_d, max_q;

    always_comb begin
        runmax_d = (pop > runmax_q) ? pop : runmax_q;
    end

    // Running per-frame max, captured at close and cleared on result transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            runmax_q <= '0;
            max_q    <= '0;
        end else if (state_q == ST_ACCUM && accept) begin
            runmax_q <= runmax_d;
            if (close) max_q <= runmax_d;
        end else if (state_q == ST_DONE && bus.dout_ready) begin
            runmax_q <= '0;
        end
    end

    assign bus.dout_max = max_q;
`endif

    // Frame FSM; handshake outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            wcnt_q  <= '0;
            dout_q  <= '0;
            words_q <= '0;
            trunc_q <= 1'b0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_ACCUM: begin
                    if (accept) begin
                        acc_q  <= acc_d;
                        wcnt_q <= wcnt_d;
                        if (close) begin
                            dout_q  <= acc_d;
                            words_q <= wcnt_d;
                            trunc_q <= !bus.din_last;
                            rdy_q   <= 1'b0;
                            vld_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.dout_ready) begin
                        acc_q   <= '0;
                        wcnt_q  <= '0;
                        rdy_q   <= 1'b1;
                        vld_q   <= 1'b0;
                        state_q <= trunc_q ? ST_DROP : ST_ACCUM;
                    end
                end
                ST_DROP: begin
                    if (accept && bus.din_last) state_q <= ST_ACCUM;
                end
                default: begin
                    state_q <= ST_ACCUM;
                    rdy_q   <= 1'b1;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.din_ready  = rdy_q;
    assign bus.dout_valid = vld_q;
    assign bus.dout       = dout_q;
    assign bus.dout_words = words_q;
    assign bus.dout_trunc = trunc_q;

endmodule
